// File: rtl/para_hit_gen.sv
// para_hit_gen -- parametrised hit detector for the para path.
//
// Watches the sample stream and declares a hit once the signal has stayed at
// or above cfg_th for cfg_hdt valid samples. While a hit is held (LOCK) every
// rising crossing back over threshold adds one ring. The hit is released once
// the signal has stayed below threshold for cfg_ldt valid samples, and one
// ph_ring/ph_vld record is then emitted.
//
// Optional feature: define PARA_HIT_PEAK_EN to add ph_peak, the largest
// sample seen during the hit, loaded together with ph_ring.
//
// Ports:
//   clk_sys, rst_n          clock, asynchronous active-low reset
//   sm_data, sm_vld         sample and its one-cycle strobe
//   cfg_en                  detector enable; low aborts any hit in progress
//   cfg_th                  threshold (signed compare when SIGNED_CMP=1)
//   cfg_hdt, cfg_ldt        hit / release durations in samples (0 acts as 1)
//   stu_now_hit             last valid sample was at or above threshold
//   stu_now_lock            a hit is currently held
//   stu_hit_id              number of declared hits (wraps)
//   stu_ring                ring count of the last completed hit
//   ph_ring, ph_vld         hit record and its one-cycle strobe
//   ph_peak                 peak sample of the hit (PARA_HIT_PEAK_EN only)
module para_hit_gen #(
    parameter int DW         = 16,
    parameter int CW         = 32,
    parameter int RW         = 16,
    parameter int IW         = 16,
    parameter bit SIGNED_CMP = 1'b0
) (
    input  logic          clk_sys,
    input  logic          rst_n,
    input  logic [DW-1:0] sm_data,
    input  logic          sm_vld,
    input  logic          cfg_en,
    input  logic [DW-1:0] cfg_th,
    input  logic [CW-1:0] cfg_hdt,
    input  logic [CW-1:0] cfg_ldt,
    output logic          stu_now_hit,
    output logic          stu_now_lock,
    output logic [IW-1:0] stu_hit_id,
    output logic [RW-1:0] stu_ring,
    output logic [RW-1:0] ph_ring,
    output logic          ph_vld
`ifdef PARA_HIT_PEAK_EN
    ,
    output logic [DW-1:0] ph_peak
`endif
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_QUAL = 2'd1;
    localparam logic [1:0] ST_LOCK = 2'd2;

    localparam logic [CW-1:0] C_ONE = {{(CW-1){1'b0}}, 1'b1};

    logic [1:0]    state;
    logic [CW-1:0] hcnt;
    logic [CW-1:0] qcnt;
    logic [RW-1:0] ring;
    logic          prev_above;

    // a >= b with the configured signedness; shared by threshold and peak.
    function automatic logic ge(input logic [DW-1:0] a, input logic [DW-1:0] b);
        if (SIGNED_CMP) ge = ($signed(a) >= $signed(b));
        else            ge = (a >= b);
    endfunction

    logic          above;
    logic [CW-1:0] hdt_eff, ldt_eff;
    logic          hcnt_done, qcnt_done;
    logic          enter_lock, release_lock;

    assign above   = ge(sm_data, cfg_th);
    assign hdt_eff = (cfg_hdt == '0) ? C_ONE : cfg_hdt;
    assign ldt_eff = (cfg_ldt == '0) ? C_ONE : cfg_ldt;

    // One bit wider so a saturated counter can never alias onto a duration.
    assign hcnt_done = ({1'b0, hcnt} + 1'b1) == {1'b0, hdt_eff};
    assign qcnt_done = ({1'b0, qcnt} + 1'b1) == {1'b0, ldt_eff};

    assign enter_lock   = cfg_en && sm_vld && above &&
                          (((state == ST_IDLE) && (hdt_eff == C_ONE)) ||
                           ((state == ST_QUAL) && hcnt_done));
    assign release_lock = cfg_en && sm_vld && !above &&
                          (state == ST_LOCK) && qcnt_done;

    assign stu_now_lock = (state == ST_LOCK);

`ifdef PARA_HIT_PEAK_EN
    logic [DW-1:0] peak;
    logic [DW-1:0] peak_nxt;
    assign peak_nxt = ge(sm_data, peak) ? sm_data : peak;

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            peak    <= '0;
            ph_peak <= '0;
        end else begin
            if (enter_lock)
                peak <= sm_data;
            else if (sm_vld && (state == ST_LOCK))
                peak <= peak_nxt;
            if (release_lock)
                ph_peak <= peak_nxt;
        end
    end
`endif

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            hcnt        <= '0;
            qcnt        <= '0;
            ring        <= '0;
            prev_above  <= 1'b0;
            stu_now_hit <= 1'b0;
            stu_hit_id  <= '0;
            stu_ring    <= '0;
            ph_ring     <= '0;
            ph_vld      <= 1'b0;
        end else begin
            ph_vld <= 1'b0;
            if (sm_vld)
                stu_now_hit <= above;

            if (!cfg_en) begin
                // Abort: record and hit id are left untouched.
                state <= ST_IDLE;
                hcnt  <= '0;
                qcnt  <= '0;
                ring  <= '0;
            end else if (enter_lock) begin
                state      <= ST_LOCK;
                hcnt       <= '0;
                qcnt       <= '0;
                ring       <= '0;
                prev_above <= 1'b1;
                stu_hit_id <= stu_hit_id + 1'b1;
            end else if (release_lock) begin
                state    <= ST_IDLE;
                qcnt     <= '0;
                ph_ring  <= ring;
                stu_ring <= ring;
                ph_vld   <= 1'b1;
            end else if (sm_vld) begin
                case (state)
                    ST_IDLE: begin
                        if (above) begin
                            state <= ST_QUAL;
                            hcnt  <= C_ONE;
                        end
                    end
                    ST_QUAL: begin
                        if (!above) begin
                            state <= ST_IDLE;
                            hcnt  <= '0;
                        end else if (!(&hcnt)) begin
                            hcnt <= hcnt + 1'b1;
                        end
                    end
                    ST_LOCK: begin
                        prev_above <= above;
                        if (above) begin
                            qcnt <= '0;
                            if (!prev_above && !(&ring))
                                ring <= ring + 1'b1;
                        end else if (!(&qcnt)) begin
                            qcnt <= qcnt + 1'b1;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_para_hit_gen.sv
// Bench for para_hit_gen: an unsigned and a signed instance share one input
// stream. A run-length model of each is stepped on every clock and compared on
// every falling edge; directed sequences with literal expectations pin the
// model, then randomized segments exercise it.
module tb_para_hit_gen;

    logic        clk_sys = 1'b0;
    logic        rst_n   = 1'b0;
    logic [15:0] sm_data = '0;
    logic        sm_vld  = 1'b0;
    logic        cfg_en  = 1'b0;
    logic [15:0] cfg_th  = '0;
    logic [31:0] cfg_hdt = '0;
    logic [31:0] cfg_ldt = '0;

    logic        u_now_hit, u_now_lock, u_ph_vld;
    logic [15:0] u_hit_id, u_stu_ring, u_ph_ring;
    logic        s_now_hit, s_now_lock, s_ph_vld;
    logic [15:0] s_hit_id, s_stu_ring, s_ph_ring;
`ifdef PARA_HIT_PEAK_EN
    logic [15:0] u_ph_peak, s_ph_peak;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk_sys = ~clk_sys;

    para_hit_gen #(.SIGNED_CMP(1'b0)) u_dut (
        .clk_sys(clk_sys), .rst_n(rst_n), .sm_data(sm_data), .sm_vld(sm_vld),
        .cfg_en(cfg_en), .cfg_th(cfg_th), .cfg_hdt(cfg_hdt), .cfg_ldt(cfg_ldt),
        .stu_now_hit(u_now_hit), .stu_now_lock(u_now_lock), .stu_hit_id(u_hit_id),
        .stu_ring(u_stu_ring), .ph_ring(u_ph_ring), .ph_vld(u_ph_vld)
`ifdef PARA_HIT_PEAK_EN
        , .ph_peak(u_ph_peak)
`endif
    );

    para_hit_gen #(.SIGNED_CMP(1'b1)) s_dut (
        .clk_sys(clk_sys), .rst_n(rst_n), .sm_data(sm_data), .sm_vld(sm_vld),
        .cfg_en(cfg_en), .cfg_th(cfg_th), .cfg_hdt(cfg_hdt), .cfg_ldt(cfg_ldt),
        .stu_now_hit(s_now_hit), .stu_now_lock(s_now_lock), .stu_hit_id(s_hit_id),
        .stu_ring(s_stu_ring), .ph_ring(s_ph_ring), .ph_vld(s_ph_vld)
`ifdef PARA_HIT_PEAK_EN
        , .ph_peak(s_ph_peak)
`endif
    );

    // ---------------- behavioural model ----------------
    // "run" is the length of the current above-threshold run before a hit;
    // "quiet" the length of the current below-threshold run while holding.
    typedef struct {
        bit          locked;
        int unsigned run;
        int unsigned quiet;
        int unsigned rings;
        bit          prev;
        bit          now_hit;
        logic [15:0] hit_id;
        logic [15:0] last_ring;
        logic [15:0] rec_ring;
        logic [15:0] peak;
        logic [15:0] rec_peak;
        bit          strobe;
    } mdl_t;

    mdl_t m_u, m_s;

    function automatic bit m_ge(input bit sgn, input logic [15:0] a, input logic [15:0] b);
        if (sgn) return $signed(a) >= $signed(b);
        return a >= b;
    endfunction

    function automatic mdl_t m_zero();
        mdl_t z;
        z.locked = 0; z.run = 0; z.quiet = 0; z.rings = 0; z.prev = 0;
        z.now_hit = 0; z.hit_id = '0; z.last_ring = '0; z.rec_ring = '0;
        z.peak = '0; z.rec_peak = '0; z.strobe = 0;
        return z;
    endfunction

    function automatic mdl_t m_step(input mdl_t m, input bit sgn, input bit en,
                                    input bit v, input logic [15:0] d, input logic [15:0] th,
                                    input int unsigned hdt, input int unsigned ldt);
        bit ab;
        int unsigned heff, leff;
        ab   = m_ge(sgn, d, th);
        heff = (hdt == 0) ? 1 : hdt;
        leff = (ldt == 0) ? 1 : ldt;
        m.strobe = 0;
        if (v) m.now_hit = ab;
        if (!en) begin
            m.locked = 0; m.run = 0; m.quiet = 0; m.rings = 0;
            return m;
        end
        if (!v) return m;
        if (!m.locked) begin
            if (ab) begin
                m.run++;
                if (m.run >= heff) begin
                    m.locked = 1; m.run = 0; m.quiet = 0; m.rings = 0; m.prev = 1;
                    m.hit_id = m.hit_id + 16'd1;
                    m.peak = d;
                end
            end else begin
                m.run = 0;
            end
        end else begin
            if (m_ge(sgn, d, m.peak)) m.peak = d;
            if (ab) begin
                if (!m.prev && m.rings < 65535) m.rings++;
                m.quiet = 0;
            end else begin
                m.quiet++;
                if (m.quiet >= leff) begin
                    m.strobe = 1;
                    m.rec_ring = 16'(m.rings);
                    m.last_ring = 16'(m.rings);
                    m.rec_peak = m.peak;
                    m.locked = 0; m.quiet = 0;
                end
            end
            m.prev = ab;
        end
        return m;
    endfunction

    always @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            m_u = m_zero();
            m_s = m_zero();
        end else begin
            m_u = m_step(m_u, 1'b0, cfg_en, sm_vld, sm_data, cfg_th, cfg_hdt, cfg_ldt);
            m_s = m_step(m_s, 1'b1, cfg_en, sm_vld, sm_data, cfg_th, cfg_hdt, cfg_ldt);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk_sys) begin
        if (rst_n) begin
            chk("u.now_hit",  u_now_hit,  m_u.now_hit);
            chk("u.now_lock", u_now_lock, m_u.locked);
            chk("u.hit_id",   u_hit_id,   m_u.hit_id);
            chk("u.stu_ring", u_stu_ring, m_u.last_ring);
            chk("u.ph_ring",  u_ph_ring,  m_u.rec_ring);
            chk("u.ph_vld",   u_ph_vld,   m_u.strobe);
            chk("s.now_hit",  s_now_hit,  m_s.now_hit);
            chk("s.now_lock", s_now_lock, m_s.locked);
            chk("s.hit_id",   s_hit_id,   m_s.hit_id);
            chk("s.stu_ring", s_stu_ring, m_s.last_ring);
            chk("s.ph_ring",  s_ph_ring,  m_s.rec_ring);
            chk("s.ph_vld",   s_ph_vld,   m_s.strobe);
`ifdef PARA_HIT_PEAK_EN
            chk("u.ph_peak",  u_ph_peak,  m_u.rec_peak);
            chk("s.ph_peak",  s_ph_peak,  m_s.rec_peak);
`endif
        end
    end

    // ---------------- stimulus helpers ----------------
    // Inputs change at negedge+1; outputs are read at the next negedge+1.
    task automatic step_in(input bit v, input logic [15:0] d);
        sm_vld  = v;
        sm_data = d;
        @(posedge clk_sys);
        @(negedge clk_sys);
        #1;
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        sm_vld = 1'b0;
        @(posedge clk_sys);
        @(negedge clk_sys);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic set_cfg(input logic [15:0] th, input int hdt, input int ldt);
        cfg_th  = th;
        cfg_hdt = 32'(hdt);
        cfg_ldt = 32'(ldt);
        cfg_en  = 1'b1;
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, ".now_hit"},  u_now_hit,  0);
        chk({nm, ".now_lock"}, u_now_lock, 0);
        chk({nm, ".hit_id"},   u_hit_id,   0);
        chk({nm, ".stu_ring"}, u_stu_ring, 0);
        chk({nm, ".ph_ring"},  u_ph_ring,  0);
        chk({nm, ".ph_vld"},   u_ph_vld,   0);
    endtask

    initial begin
        logic [15:0] d;
        bit v;

        #1;
        do_reset();
        chk_all_zero("reset");

        // 1: basic hit and release
        set_cfg(16'd100, 3, 2);
        step_in(1, 16'd50);
        step_in(1, 16'd120);
        step_in(1, 16'd130);
        chk("t1.lock_pre", u_now_lock, 0);
        step_in(1, 16'd140);
        chk("t1.lock", u_now_lock, 1);
        chk("t1.hit_id", u_hit_id, 1);
        step_in(1, 16'd10);
        chk("t1.vld_early", u_ph_vld, 0);
        step_in(1, 16'd20);
        chk("t1.ph_vld", u_ph_vld, 1);
        chk("t1.ph_ring", u_ph_ring, 0);
        chk("t1.unlock", u_now_lock, 0);
        step_in(0, 16'd0);
        chk("t1.ph_vld_off", u_ph_vld, 0);

        // 2: interrupted qualification
        do_reset();
        set_cfg(16'd100, 3, 2);
        step_in(1, 16'd120);
        step_in(1, 16'd130);
        step_in(1, 16'd50);
        step_in(1, 16'd120);
        step_in(1, 16'd130);
        chk("t2.id_pre", u_hit_id, 0);
        step_in(1, 16'd140);
        chk("t2.id", u_hit_id, 1);

        // 3: ring crossings
        do_reset();
        set_cfg(16'd100, 1, 4);
        step_in(1, 16'd150);
        step_in(1, 16'd90);
        step_in(1, 16'd150);
        step_in(1, 16'd90);
        step_in(1, 16'd150);
        step_in(1, 16'd90);
        step_in(1, 16'd90);
        step_in(1, 16'd90);
        chk("t3.vld_early", u_ph_vld, 0);
        step_in(1, 16'd90);
        chk("t3.ph_vld", u_ph_vld, 1);
        chk("t3.ph_ring", u_ph_ring, 2);
        chk("t3.stu_ring", u_stu_ring, 2);
        step_in(0, 16'd0);
        chk("t3.single", u_ph_vld, 0);
        chk("t3.hold", u_ph_ring, 2);

        // 4: zero durations behave as one
        do_reset();
        set_cfg(16'd100, 0, 0);
        step_in(1, 16'd200);
        chk("t4.lock", u_now_lock, 1);
        step_in(1, 16'd5);
        chk("t4.ph_vld", u_ph_vld, 1);
        chk("t4.hit_id", u_hit_id, 1);

        // 5a: enable drop aborts; low enable beats the simultaneous sample
        do_reset();
        set_cfg(16'd100, 1, 4);
        step_in(1, 16'd150);
        cfg_en = 1'b0;
        step_in(1, 16'd50);
        chk("t5a.unlock", u_now_lock, 0);
        chk("t5a.ph_vld", u_ph_vld, 0);
        chk("t5a.hit_id", u_hit_id, 1);
        cfg_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step_in(1, 16'd50);
            chk("t5a.no_vld", u_ph_vld, 0);
        end

        // 5b: async reset mid-hit clears outputs at once
        step_in(1, 16'd150);
        chk("t5b.lock", u_now_lock, 1);
        sm_vld = 1'b0;
        @(posedge clk_sys);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("t5b");
        @(negedge clk_sys);
        #1;
        rst_n = 1'b1;

        // 6: signed compare
        set_cfg(16'hFFF6, 1, 1);
        step_in(1, 16'hFFF0);
        chk("t6.s_nolock", s_now_lock, 0);
        step_in(1, 16'h0005);
        chk("t6.s_lock", s_now_lock, 1);
        chk("t6.u_nolock", u_now_lock, 0);

`ifdef PARA_HIT_PEAK_EN
        do_reset();
        set_cfg(16'd10, 1, 1);
        step_in(1, 16'd20);
        step_in(1, 16'd80);
        step_in(1, 16'd40);
        step_in(1, 16'd5);
        chk("t6.ph_vld", u_ph_vld, 1);
        chk("t6.peak", u_ph_peak, 80);
`endif

        // randomized segments; config only changes while disabled
        do_reset();
        for (int seg = 0; seg < 30; seg++) begin
            cfg_en = 1'b0;
            step_in(0, 16'd0);
            set_cfg(16'($urandom_range(0, 255)) - 16'd128,
                    int'($urandom_range(0, 4)), int'($urandom_range(0, 4)));
            for (int c = 0; c < 60; c++) begin
                v = ($urandom_range(0, 9) < 7);
                d = 16'($urandom_range(0, 255)) - 16'd128;
                cfg_en = ($urandom_range(0, 99) != 0);
                step_in(v, d);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Backstop so the bench always ends.
    initial begin
        #500000;
        n_fail++;
        $display("FAIL timeout: got no end expected end");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/para_hit_gen.md
Name: para_hit_gen

Overview:
- Parametrised successor to the single-channel hit detector in the para path.
- Watches the sample stream `sm_data`/`sm_vld` and qualifies a "hit" once the signal stays above threshold for `cfg_hdt` samples.
- Holds lock until the signal stays below threshold for `cfg_ldt` samples, counting ring crossings while locked.
- Emits one `ph_ring`/`ph_vld` record per hit. Sits between the sample mux and the para record builder; status outputs feed the register file.

Parameters:
- DW, 16: sample and threshold width.
- CW, 32: width of the hdt/ldt duration counters and cfg_hdt/cfg_ldt.
- RW, 16: ring counter width, also the width of ph_ring and stu_ring.
- IW, 16: hit id width.
- SIGNED_CMP, 0: 1 = signed threshold compare, 0 = unsigned.

Ports:
- clk_sys  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- sm_data  in  DW  sample
- sm_vld  in  1  sample strobe, one cycle per sample
- cfg_en  in  1  detector enable
- cfg_th  in  DW  threshold
- cfg_hdt  in  CW  above-threshold samples needed to declare a hit
- cfg_ldt  in  CW  below-threshold samples needed to release lock
- stu_now_hit  out  1  last valid sample was above threshold
- stu_now_lock  out  1  FSM is in LOCK
- stu_hit_id  out  IW  count of declared hits
- stu_ring  out  RW  ring count of the last completed hit
- ph_ring  out  RW  ring count record
- ph_vld  out  1  one-cycle record strobe

Behaviour:
- **Clock/reset.** One clock, clk_sys. Reset is asynchronous, active-low (rst_n). All outputs and state reset to 0 and the FSM to IDLE.
- **Threshold compare.** above = (sm_data >= cfg_th), evaluated only when sm_vld=1. It is signed when SIGNED_CMP=1, otherwise unsigned. Samples with sm_vld=0 change nothing.
- **stu_now_hit.** Registered `above` of the last valid sample, so it updates the cycle after sm_vld.
- **Effective durations.** hdt_eff = max(cfg_hdt,1) and ldt_eff = max(cfg_ldt,1). A value of 0 behaves as 1.
- **IDLE:**
  - vld & above & hdt_eff==1 → LOCK.
  - vld & above otherwise → QUAL with hcnt=1.
  - Otherwise stay in IDLE.
- **QUAL:**
  - vld & below → IDLE, hcnt=0.
  - vld & above → hcnt++; when hcnt+1 == hdt_eff → LOCK.
- **Entry to LOCK.**
  - stu_hit_id++ (wraps modulo 2^IW).
  - ring=0, qcnt=0, prev_above=1.
  - stu_now_lock goes to 1 the cycle after the qualifying sample.
- **LOCK, ring counting.** A vld sample with above=1 and prev_above=0 increments ring. Ring saturates at 2^RW-1.
- **LOCK, quiet counting.**
  - vld & below: qcnt++.
  - vld & above: qcnt=0.
  - When qcnt+1 == ldt_eff on a below sample: ph_ring<=ring, stu_ring<=ring, ph_vld=1 for exactly one cycle, FSM → IDLE, stu_now_lock=0.
  - Latency: ph_vld is asserted the cycle after the releasing sample.
- **Duration counters.** hcnt and qcnt saturate at 2^CW-1 and never wrap.
- **cfg_en=0.**
  - Forces IDLE next cycle and clears hcnt, qcnt and ring.
  - If the FSM was in LOCK, the hit is aborted: no ph_vld is produced, and stu_ring and stu_hit_id are left unchanged.
  - cfg_en low has priority over any simultaneous sample.
- **Config changes.** cfg_th, cfg_hdt and cfg_ldt are sampled live. A change mid-hit applies to the next compare.
- **ph_ring hold.** ph_ring holds its value between strobes.
- **Back-to-back hits.** Supported: a valid sample on the cycle after release is evaluated from IDLE.

Optional Feature:
- Macro PARA_HIT_PEAK_EN.
- **Defined:**
  - Adds output ph_peak [DW] and register peak.
  - At LOCK entry, peak = the qualifying sample.
  - In LOCK, peak = max(peak, sm_data) on each vld, using the same signedness as SIGNED_CMP.
  - ph_peak is loaded together with ph_ring on release and resets to 0.
- **Undefined:** the port and logic are absent; all other behaviour is identical.

Test Plan:
1. th=100, hdt=3, ldt=2, samples 50,120,130,140,10,20 → hit declared on sample 140; stu_hit_id=1; ph_vld one cycle after sample 20 with ph_ring=0.
2. th=100, hdt=3, samples 120,130,50,120,130,140 → the first run aborts back to IDLE; stu_hit_id=1 only after the final 140.
3. Locked with hdt=1, ldt=4, samples 150,90,150,90,150,90,90,90,90 → 2 ring crossings; ph_ring=2, stu_ring=2, single ph_vld.
4. cfg_hdt=0, cfg_ldt=0, th=100, samples 200,5 → lock on 200, release on 5; ph_vld pulse; stu_hit_id=1.
5. Mid-LOCK cfg_en=0, or rst_n low in any state → no ph_vld; FSM IDLE.
   - cfg_en abort: stu_hit_id unchanged.
   - rst_n abort: all outputs are 0 immediately.
6. SIGNED_CMP=1, th=-10 (0xFFF6), samples 0xFFF0, 0x0005, hdt=1 → no hit on 0xFFF0 (-16), hit on 5.
   - With PARA_HIT_PEAK_EN, samples 20,80,40 then release → ph_peak=80.
